fp_division: RTL and testbench
==============================

FP_DIVISION -- requirements
Module: fp_division

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, ports listed first: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-003 SHALL have port A  input  32  IEEE-754 single-precision dividend; sampled with start.
REQ-004 SHALL have port B  input  32  IEEE-754 single-precision divisor; sampled with start.
REQ-005 SHALL have port result  output  32  quotient; holds its value until the next accepted start.
REQ-006 SHALL have port busy  output  1  high in every state except IDLE.
REQ-007 SHALL have port done  output  1  one-cycle pulse; result and flags valid in that cycle.
REQ-008 SHALL have ports exception, overflow, underflow, divide_by_zero  output  1 each  status flags, registered with result.

Function
REQ-009 SHALL implement states IDLE, DIVIDE, NORM, DONE: IDLE->DIVIDE on start, DIVIDE->NORM after 26 iterations, NORM->DONE, DONE->IDLE.
REQ-010 SHALL ignore start while busy=1; A and B are not re-sampled.
REQ-011 SHALL use a fixed latency for every operand class, special cases included: done high in the cycle after the 28th rising edge following the edge that samples start.
REQ-012 SHALL compute sign = A[31] xor B[31].
REQ-013 SHALL form the 24-bit significands {1,frac}; an exponent field of 0 is treated as zero (denormals flushed).
REQ-014 SHALL compute the biased exponent as EA - EB + 127 in 10-bit signed arithmetic.
REQ-015 SHALL generate a 26-bit quotient Q = floor(MA*2^25/MB) by restoring division, one bit per DIVIDE cycle, MSB first.
REQ-016 SHALL normalise in NORM: if Q[25]=1, mantissa=Q[25:2], guard=Q[1], sticky=Q[0]|(remainder!=0); otherwise mantissa=Q[24:1], guard=Q[0], sticky=(remainder!=0), and the exponent is decremented by 1.
REQ-017 SHALL apply rounding per REQ-030/031; a mantissa carry-out increments the exponent.
REQ-018 SHALL select result with priority: exception (EA=255 or EB=255) -> 32'h0, exception=1; divisor zero -> {sign,8'hFF,23'h0}, divide_by_zero=1; dividend zero -> {sign,31'h0}; exponent>=255 -> {sign,8'hFE,23'h7FFFFF}, overflow=1; exponent<=0 -> {sign,31'h0}, underflow=1; otherwise {sign,exp[7:0],mant[22:0]}.
REQ-019 SHALL assert at most one of exception, divide_by_zero, overflow, underflow per operation.
REQ-020 SHALL hold all flags until the next accepted start, which clears them.

Reset
REQ-021 SHALL, while rst_n=0, force state=IDLE, result=0, busy=0, done=0 and all flags=0 regardless of clk.
REQ-022 SHALL abort any in-flight division on reset without producing done; no partial result is retained.
REQ-023 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with macro FP_DIV_ROUND_EN defined, round to nearest even: increment the mantissa when guard & (sticky | mant[0]).
REQ-031 SHALL, without FP_DIV_ROUND_EN, truncate (guard and sticky ignored); latency is identical in both builds.

Verification
REQ-040 SHALL cover: A=0x40C00000, B=0x40000000 -> result=0x40400000, all flags 0, done 28 edges after start.
REQ-041 SHALL cover: A=0x3F800000, B=0x40400000 -> 0x3EAAAAAB with FP_DIV_ROUND_EN, 0x3EAAAAAA without.
REQ-042 SHALL cover: A=0xBF800000, B=0x40000000 -> 0xBF000000; and A=0x3F800000, B=0x00000000 -> 0x7F800000, divide_by_zero=1.
REQ-043 SHALL cover: A=0x7F000000, B=0x3E800000 -> 0x7F7FFFFF, overflow=1; and A=0x00800000, B=0x40000000 -> 0x00000000, underflow=1.
REQ-044 SHALL cover: A=0x7F800000, any B -> 0x00000000, exception=1; and a second start pulsed mid-DIVIDE is ignored, with the first result unchanged.
REQ-045 SHALL cover: rst_n pulsed low at iteration 10 -> busy=0 immediately, no done pulse, and the next start completes normally.

Source files
------------

// File: rtl/fp_division_if.sv
// Request/response bundle for the fp_division single-precision divider.
// master drives operands and start; slave returns quotient, status and handshake.
interface fp_division_if;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        exception;
    logic        overflow;
    logic        underflow;
    logic        divide_by_zero;

    modport master (
        output start, A, B,
        input  result, busy, done, exception, overflow, underflow, divide_by_zero
    );

    modport slave (
        input  start, A, B,
        output result, busy, done, exception, overflow, underflow, divide_by_zero
    );
endinterface

// File: rtl/fp_division.sv
// Iterative IEEE-754 single-precision divider, 26-cycle restoring core, fixed 28-edge latency.
// Define FP_DIV_ROUND_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fp_division (
    input  logic          clk,
    input  logic          rst_n,
    fp_division_if.slave  bus
);
    localparam int unsigned EXP_W  = 10;
    localparam int unsigned SIG_W  = 24;
    localparam int unsigned QUO_W  = 26;
    localparam int unsigned REM_W  = 25;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned LAST_IT = QUO_W - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [REM_W-1:0]        rem_q;
    logic [SIG_W-1:0]        mb_q;
    logic [QUO_W-1:0]        quo_q;
    logic signed [EXP_W-1:0] exp_q;
    logic [22:0]             mant_q;
    logic                    sign_q;
    logic                    exc_q;
    logic                    dbz_q;
    logic                    az_q;

    logic [31:0]             result_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    exception_q;
    logic                    overflow_q;
    logic                    underflow_q;
    logic                    divide_by_zero_q;

    logic [7:0]              ea;
    logic [7:0]              eb;
    logic [SIG_W-1:0]        ma;
    logic [SIG_W-1:0]        mb;
    logic                    ge;
    logic [REM_W-1:0]        rem_d;
    logic [QUO_W-1:0]        quo_d;
    logic [SIG_W-1:0]        mant_n;
    logic                    guard;
    logic                    sticky;
    logic                    round_inc;
    logic                    carry;
    logic signed [EXP_W-1:0] exp_n;
    logic signed [EXP_W-1:0] exp_d;
    logic [22:0]             mant_d;
    logic [31:0]             result_d;
    logic [3:0]              flags_d;

    // Operand unpack with denormals flushed to zero.
    always_comb begin
        ea = bus.A[30:23];
        eb = bus.B[30:23];
        ma = (ea == 8'd0) ? '0 : {1'b1, bus.A[22:0]};
        mb = (eb == 8'd0) ? '0 : {1'b1, bus.B[22:0]};
    end

    // One restoring step: trial-subtract, keep on success, shift the partial remainder.
    always_comb begin
        ge    = (rem_q >= {1'b0, mb_q});
        rem_d = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
        rem_d = rem_d << 1;
        quo_d = {quo_q[QUO_W-2:0], ge};
    end

    // Normalise, then round; a 24-bit all-ones mantissa rolls over into the exponent.
    always_comb begin
        if (quo_q[QUO_W-1]) begin
            mant_n = quo_q[25:2];
            guard  = quo_q[1];
            sticky = quo_q[0] | (rem_q != '0);
            exp_n  = exp_q;
        end else begin
            mant_n = quo_q[24:1];
            guard  = quo_q[0];
            sticky = (rem_q != '0);
            exp_n  = exp_q - EXP_W'(1);
        end
`ifdef FP_DIV_ROUND_EN
        round_inc = guard & (sticky | mant_n[0]);
`else
        round_inc = 1'b0 & guard & sticky;
`endif
        carry  = round_inc & (&mant_n);
        mant_d = mant_n[22:0] + 23'(round_inc);
        exp_d  = exp_n + EXP_W'(carry);
    end

    // Final result select; flags_d = {exception, divide_by_zero, overflow, underflow}.
    always_comb begin
        result_d = {sign_q, exp_q[7:0], mant_q};
        flags_d  = 4'b0000;
        if (exc_q) begin
            result_d = 32'h0;
            flags_d  = 4'b1000;
        end else if (dbz_q) begin
            result_d = {sign_q, 8'hFF, 23'h0};
            flags_d  = 4'b0100;
        end else if (az_q) begin
            result_d = {sign_q, 31'h0};
        end else if (exp_q >= 10'sd255) begin
            result_d = {sign_q, 8'hFE, 23'h7FFFFF};
            flags_d  = 4'b0010;
        end else if (exp_q <= 10'sd0) begin
            result_d = {sign_q, 31'h0};
            flags_d  = 4'b0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            rem_q            <= '0;
            mb_q             <= '0;
            quo_q            <= '0;
            exp_q            <= '0;
            mant_q           <= '0;
            sign_q           <= 1'b0;
            exc_q            <= 1'b0;
            dbz_q            <= 1'b0;
            az_q             <= 1'b0;
            result_q         <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            exception_q      <= 1'b0;
            overflow_q       <= 1'b0;
            underflow_q      <= 1'b0;
            divide_by_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q          <= DIVIDE;
                        busy_q           <= 1'b1;
                        cnt_q            <= '0;
                        rem_q            <= REM_W'(ma);
                        mb_q             <= mb;
                        quo_q            <= '0;
                        sign_q           <= bus.A[31] ^ bus.B[31];
                        exp_q            <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
                        exc_q            <= (ea == 8'hFF) || (eb == 8'hFF);
                        dbz_q            <= (eb == 8'h00);
                        az_q             <= (ea == 8'h00);
                        exception_q      <= 1'b0;
                        overflow_q       <= 1'b0;
                        underflow_q      <= 1'b0;
                        divide_by_zero_q <= 1'b0;
                    end
                end
                DIVIDE: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LAST_IT)) begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    mant_q  <= mant_d;
                    exp_q   <= exp_d;
                    state_q <= DONE;
                end
                DONE: begin
                    result_q         <= result_d;
                    exception_q      <= flags_d[3];
                    divide_by_zero_q <= flags_d[2];
                    overflow_q       <= flags_d[1];
                    underflow_q      <= flags_d[0];
                    done_q           <= 1'b1;
                    busy_q           <= 1'b0;
                    state_q          <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.result         = result_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.exception      = exception_q;
    assign bus.overflow       = overflow_q;
    assign bus.underflow      = underflow_q;
    assign bus.divide_by_zero = divide_by_zero_q;
endmodule

// File: tb/tb_fp_division.sv
// Directed bench for fp_division: hand-computed quotients, flags, latency, abort on reset.
// Follows the FP_DIV_ROUND_EN define for the rounding-sensitive vector.
module tb_fp_division;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    fp_division_if bus ();

    fp_division u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] flags();
        return {28'h0, bus.exception, bus.divide_by_zero, bus.overflow, bus.underflow};
    endfunction

    // flag order: {exception, divide_by_zero, overflow, underflow}; poke_at>0 re-pulses start mid-DIVIDE
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic [3:0] exp_f, input int poke_at);
        int   lat;
        logic [31:0] res;
        lat = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == poke_at) begin
                bus.start = 1'b1;
                bus.A     = 32'h3F800000;
                bus.B     = 32'h3F800000;
            end else if (n == poke_at + 1) begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        bus.start = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'd28);
        chk({tag, "_res"}, bus.result, exp_r);
        chk({tag, "_flg"}, flags(), {28'h0, exp_f});
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        res = bus.result;
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_hold"}, bus.result, exp_r);
    endtask

    initial begin
        logic [31:0] third;
        n_total   = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
`ifdef FP_DIV_ROUND_EN
        third = 32'h3EAAAAAB;
`else
        third = 32'h3EAAAAAA;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res",  bus.result, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_flg",  flags(), 32'h0);
        rst_n = 1'b1;

        run_op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 0);
        run_op("one_third",  32'h3F800000, 32'h40400000, third,        4'b0000, 0);
        run_op("neg_half",   32'hBF800000, 32'h40000000, 32'hBF000000, 4'b0000, 0);
        run_op("div_zero",   32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 0);
        run_op("ovf",        32'h7F000000, 32'h3E800000, 32'h7F7FFFFF, 4'b0010, 0);
        run_op("unf",        32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 0);
        run_op("exc",        32'h7F800000, 32'h40000000, 32'h00000000, 4'b1000, 0);
        run_op("ignore_go",  32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 5);

        // abort at iteration 10: outputs drop at once, no done while held in reset
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 32'h3F800000;
        bus.B     = 32'h40400000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_res",  bus.result, 32'h0);
        begin
            logic seen;
            seen = 1'b0;
            repeat (3) begin
                @(posedge clk);
                #1;
                seen = seen | bus.done;
            end
            chk("abort_nodone", 32'(seen), 32'd0);
        end
        rst_n = 1'b1;
        run_op("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
